// File: rtl/sram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared definitions for the SRAM request controller:
//   - default address/data widths
//   - packed request record {we, addr, wdata, wmask}
//   - credit check used to gate read acceptance
// ---------------------------------------------------------------------------
package sram_ctrl_pkg;

    localparam int unsigned AW_DEF = 10;
    localparam int unsigned DW_DEF = 32;

    typedef struct packed {
        logic              we;
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] wdata;
        logic [DW_DEF-1:0] wmask;
    } sram_req_t;

    // A read may only be accepted when every read already accepted but not
    // yet handed to the consumer still leaves a free response slot.
    function automatic logic credit_ok(input int unsigned cnt,
                                       input logic        inflight,
                                       input int unsigned depth);
        return (cnt + 32'(inflight)) < depth;
    endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// ---------------------------------------------------------------------------
// sram_rsp_fifo
// Synchronous response FIFO holding read words the consumer has not taken.
// Ports:
//   clk, rst   clock, synchronous active-high reset (clears pointers/count)
//   push_i     write wdata_i at the tail
//   pop_i      drop the head entry
//   wdata_i    data to push
//   rdata_o    head entry (valid when !empty_o)
//   cnt_o      number of stored entries
//   empty_o    cnt_o == 0
//   full_o     cnt_o == DEPTH
// ---------------------------------------------------------------------------
module sram_rsp_fifo #(
    parameter  int unsigned DW    = 32,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    output logic [CW-1:0] cnt_o,
    output logic          empty_o,
    output logic          full_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] cnt_q;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset; only entries covered by cnt_q are ever read.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_comb begin
        rdata_o = mem_q[rd_ptr_q];
        cnt_o   = cnt_q;
        empty_o = (cnt_q == '0);
        full_o  = (cnt_q == CW'(DEPTH));
    end

endmodule

// File: rtl/sram_req_ctrl.sv
// ---------------------------------------------------------------------------
// sram_req_ctrl
// Request-side controller in front of a single-port SRAM macro with 1-cycle
// read latency. One operation per cycle; read data is buffered so consumer
// backpressure never loses a macro output word.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake (fire = valid & ready)
//   req_we, req_addr,
//   req_wdata, req_wmask          request payload (wmask: 1 = write bit)
//   rsp_valid/rsp_ready/rsp_rdata read response stream, in request order
//   mem_cen, mem_gwen, mem_wen,
//   mem_a, mem_d                  macro pins, driven in the fire cycle
//   mem_q                         macro read data, valid cycle after a read
// ---------------------------------------------------------------------------
module sram_req_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned AW        = AW_DEF,
    parameter int unsigned DW        = DW_DEF,
    parameter int unsigned RSP_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    input  logic [DW-1:0] req_wmask,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          mem_cen,
    output logic          mem_gwen,
    output logic [DW-1:0] mem_wen,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_d,
    input  logic [DW-1:0] mem_q
);

    localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

    logic          rd_inflight_q;
    logic          rd_inflight_d;
    logic          fire;
    logic [CW-1:0] fifo_cnt;
    logic          fifo_empty;
    logic          fifo_full;
    logic          fifo_push;
    logic          fifo_pop;
    logic [DW-1:0] fifo_head;

    always_comb begin
        // Depends on req_we and local state only, never on rsp_ready.
        req_ready = !rst && (req_we || credit_ok(32'(fifo_cnt), rd_inflight_q, RSP_DEPTH));
        fire      = req_valid && req_ready;

        mem_cen  = fire;
        mem_gwen = fire && req_we;
        mem_wen  = (fire && req_we) ? req_wmask : '0;
        mem_a    = req_addr;
        mem_d    = req_wdata;

        rd_inflight_d = fire && !req_we;

        // With an empty FIFO the macro word is presented directly; it is
        // only stored if the consumer stalls. Otherwise it queues behind
        // the older entries to keep responses in order.
        rsp_valid = !rst && (!fifo_empty || rd_inflight_q);
        rsp_rdata = fifo_empty ? mem_q : fifo_head;
        fifo_push = rd_inflight_q && (!fifo_empty || !rsp_ready);
        fifo_pop  = rsp_valid && rsp_ready && !fifo_empty;
    end

    always_ff @(posedge clk) begin
        if (rst) rd_inflight_q <= 1'b0;
        else     rd_inflight_q <= rd_inflight_d;
    end

    sram_rsp_fifo #(
        .DW    (DW),
        .DEPTH (RSP_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (mem_q),
        .rdata_o (fifo_head),
        .cnt_o   (fifo_cnt),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // Credit accounting must make overflow unreachable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (32'(fifo_cnt) <= RSP_DEPTH);
            assert (!(fifo_push && fifo_full && !fifo_pop));
        end
    end

endmodule

// File: tb/tb_sram_req_ctrl.sv
module tb_sram_req_ctrl;

    localparam int unsigned AW    = 10;
    localparam int unsigned DW    = 32;
    localparam int          DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [DW-1:0] req_wmask;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          mem_cen;
    logic          mem_gwen;
    logic [DW-1:0] mem_wen;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_d;
    logic [DW-1:0] mem_q;

    always #5 clk = ~clk;

    sram_req_ctrl #(
        .AW        (AW),
        .DW        (DW),
        .RSP_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .mem_cen   (mem_cen),
        .mem_gwen  (mem_gwen),
        .mem_wen   (mem_wen),
        .mem_a     (mem_a),
        .mem_d     (mem_d),
        .mem_q     (mem_q)
    );

    // SRAM macro: per-bit write, registered read data held until next read.
    logic          init_mem = 1'b1;
    logic [DW-1:0] sram [1<<AW];
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < (1 << AW); i++) sram[i] <= '0;
            mem_q <= '0;
        end else if (mem_cen) begin
            if (mem_gwen) sram[mem_a] <= (sram[mem_a] & ~mem_wen) | (mem_d & mem_wen);
            else          mem_q <= sram[mem_a];
        end
    end

    // Request-level reference: memory contents plus the ordered list of
    // read words accepted but not yet taken by the consumer.
    logic [DW-1:0] mem_m [1<<AW];
    logic [DW-1:0] pend [$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic          r, v, we;
        logic [AW-1:0] a;
        logic [DW-1:0] wd, wm;
        logic          rr;
        logic          e_ready, e_cen, e_gwen;
        logic [DW-1:0] e_wen;
        logic          e_rv, chk_d;
        logic [DW-1:0] e_d;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(logic r, logic v, logic we, logic [AW-1:0] a,
                                logic [DW-1:0] wd, logic [DW-1:0] wm, logic rr,
                                logic er, logic ec, logic eg, logic [DW-1:0] ew,
                                logic erv, logic cd, logic [DW-1:0] ed);
        vec_t t;
        t.r = r; t.v = v; t.we = we; t.a = a; t.wd = wd; t.wm = wm; t.rr = rr;
        t.e_ready = er; t.e_cen = ec; t.e_gwen = eg; t.e_wen = ew;
        t.e_rv = erv; t.chk_d = cd; t.e_d = ed;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [DW-1:0] wm, input logic rr);
        @(negedge clk);
        cyc++;
        rst = r; req_valid = v; req_we = we; req_addr = a;
        req_wdata = wd; req_wmask = wm; rsp_ready = rr;
        #1;
    endtask

    function automatic logic m_ready();
        return !rst && (req_we || pend.size() < DEPTH);
    endfunction

    // Advance the reference across the coming posedge using current inputs.
    task automatic model_edge();
        logic rdy;
        if (rst) begin
            pend.delete();
            return;
        end
        rdy = m_ready();
        if (pend.size() > 0 && rsp_ready) void'(pend.pop_front());
        if (req_valid && rdy) begin
            if (req_we) mem_m[req_addr] = (mem_m[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
            else        pend.push_back(mem_m[req_addr]);
        end
    endtask

    task automatic run_vec(input vec_t t, input int idx);
        drive(t.r, t.v, t.we, t.a, t.wd, t.wm, t.rr);
        chk($sformatf("v%0d.req_ready", idx), 32'(req_ready), 32'(t.e_ready));
        chk($sformatf("v%0d.mem_cen", idx),   32'(mem_cen),   32'(t.e_cen));
        chk($sformatf("v%0d.mem_gwen", idx),  32'(mem_gwen),  32'(t.e_gwen));
        chk($sformatf("v%0d.mem_wen", idx),   mem_wen,        t.e_wen);
        chk($sformatf("v%0d.rsp_valid", idx), 32'(rsp_valid), 32'(t.e_rv));
        if (t.e_cen) chk($sformatf("v%0d.mem_a", idx), 32'(mem_a), 32'(t.a));
        if (t.chk_d) chk($sformatf("v%0d.rsp_rdata", idx), rsp_rdata, t.e_d);
        model_edge();
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_wmask = '0; rsp_ready = 1'b1;
        for (int i = 0; i < (1 << AW); i++) mem_m[i] = '0;
        @(posedge clk);
        #1 init_mem = 1'b0;

        // reset / idle
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1,1,0,10'h005,0,0,1,              0,0,0,0,             0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,1,                         1,0,0,0,             0,0,0));
        // write then read
        tbl.push_back(mk(0,1,1,10'h005,32'hDEADBEEF,'1,1,       1,1,1,32'hFFFFFFFF,  0,0,0));
        tbl.push_back(mk(0,1,0,10'h005,0,0,1,                   1,1,0,0,             0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,1,                         1,0,0,0,             1,1,32'hDEADBEEF));
        // partial mask
        tbl.push_back(mk(0,1,1,10'h005,0,32'h0000FFFF,1,        1,1,1,32'h0000FFFF,  0,0,0));
        tbl.push_back(mk(0,1,0,10'h005,0,0,1,                   1,1,0,0,             0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,1,                         1,0,0,0,             1,1,32'hDEAD0000));
        // backpressure: preload, then three reads with consumer stalled
        tbl.push_back(mk(0,1,1,10'h001,32'h11111111,'1,0,       1,1,1,32'hFFFFFFFF,  0,0,0));
        tbl.push_back(mk(0,1,1,10'h002,32'h22222222,'1,0,       1,1,1,32'hFFFFFFFF,  0,0,0));
        tbl.push_back(mk(0,1,1,10'h003,32'h33333333,'1,0,       1,1,1,32'hFFFFFFFF,  0,0,0));
        tbl.push_back(mk(0,1,0,10'h001,0,0,0,                   1,1,0,0,             0,0,0));
        tbl.push_back(mk(0,1,0,10'h002,0,0,0,                   1,1,0,0,             1,1,32'h11111111));
        tbl.push_back(mk(0,1,0,10'h003,0,0,0,                   0,0,0,0,             1,1,32'h11111111));
        // write accepted while full
        tbl.push_back(mk(0,1,1,10'h010,32'hA5A5A5A5,'1,0,       1,1,1,32'hFFFFFFFF,  1,1,32'h11111111));
        tbl.push_back(mk(0,1,0,10'h003,0,0,0,                   0,0,0,0,             1,1,32'h11111111));
        // release
        tbl.push_back(mk(0,1,0,10'h003,0,0,1,                   0,0,0,0,             1,1,32'h11111111));
        tbl.push_back(mk(0,1,0,10'h003,0,0,1,                   1,1,0,0,             1,1,32'h22222222));
        tbl.push_back(mk(0,0,0,0,0,0,1,                         1,0,0,0,             1,1,32'h33333333));
        tbl.push_back(mk(0,1,0,10'h010,0,0,1,                   1,1,0,0,             0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,1,                         1,0,0,0,             1,1,32'hA5A5A5A5));
        // reset while a read is in flight
        tbl.push_back(mk(0,1,0,10'h005,0,0,0,                   1,1,0,0,             0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,                         0,0,0,0,             0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,                         0,0,0,0,             0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,1,                         1,0,0,0,             0,0,0));

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

        // the dropped read must never surface
        for (int i = 0; i < 6; i++) begin
            drive(0,0,0,0,0,0,(i % 2 == 0));
            chk("rst_drop.rsp_valid", 32'(rsp_valid), 0);
            chk("rst_drop.fifo_cnt",  32'(dut.u_fifo.cnt_o), 0);
            model_edge();
        end
        run_vec(mk(0,1,0,10'h005,0,0,1, 1,1,0,0, 0,0,0), 100);
        run_vec(mk(0,0,0,0,0,0,1,       1,0,0,0, 1,1,32'hDEAD0000), 101);

        // randomized traffic against the reference
        for (int n = 0; n < 3000; n++) begin
            logic          r, v, we, rr, e_rdy, e_fire, e_rv;
            logic [AW-1:0] a;
            logic [DW-1:0] wd, wm;
            r  = ($urandom_range(0, 199) == 0);
            v  = ($urandom_range(0, 3) != 0);
            we = $urandom_range(0, 1) == 1;
            a  = AW'($urandom_range(0, 15));
            wd = $urandom;
            case ($urandom_range(0, 3))
                0:       wm = '0;
                1:       wm = '1;
                default: wm = $urandom;
            endcase
            rr = ($urandom_range(0, 3) != 0);
            drive(r, v, we, a, wd, wm, rr);
            e_rdy  = m_ready();
            e_fire = v && e_rdy;
            e_rv   = !r && pend.size() > 0;
            chk("rnd.req_ready", 32'(req_ready), 32'(e_rdy));
            chk("rnd.mem_cen",   32'(mem_cen),   32'(e_fire));
            chk("rnd.mem_gwen",  32'(mem_gwen),  32'(e_fire && we));
            chk("rnd.mem_wen",   mem_wen,        (e_fire && we) ? wm : '0);
            chk("rnd.rsp_valid", 32'(rsp_valid), 32'(e_rv));
            if (e_fire)       chk("rnd.mem_a", 32'(mem_a), 32'(a));
            if (e_fire && we) chk("rnd.mem_d", mem_d, wd);
            if (e_rv)         chk("rnd.rsp_rdata", rsp_rdata, pend[0]);
            model_edge();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
